alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 3-bit operation code produced by `ALU_Control` and applies it to the two EX-stage operands.

- Add/sub/and/or/slt complete in one registered cycle.
- MUL runs as an iterative shift-add multiply over WIDTH cycles.
- During MUL, `ready_o` is deasserted so the hazard unit holds the IF/ID/EX registers.
- Sits between the ID/EX pipeline register and the EX/MEM register.

## Interface
Parameters:
- WIDTH, 32, operand/result width; also the MUL iteration count.

Ports:
- Clock and reset: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- valid_i  in  1  operation present on ctrl_i/data1_i/data2_i
- ready_o  out  1  unit can accept an operation this cycle (combinational)
- flush_i  in  1  synchronous abort of any operation in flight
- ctrl_i  in  3  ALU_Control code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL; 100/101 reserved
- data1_i  in  WIDTH  operand A
- data2_i  in  WIDTH  operand B
- valid_o  out  1  one-cycle pulse: result_o/zero_o hold a new result
- result_o  out  WIDTH  registered result
- zero_o  out  1  registered (result_o == 0)

## Operation
- States:
  - IDLE: ready_o = 1 unless rst_i is high.
  - MUL: ready_o = 0.
- Transfer rule: an operation is accepted on a rising edge where valid_i && ready_o && !flush_i.
- Single-cycle accept (any code other than 011), in IDLE:
  - result_o, zero_o and valid_o = 1 are registered at the accepting edge.
  - State stays IDLE.
- Arithmetic (all results truncated to WIDTH):
  - ADD, SUB: modulo 2^WIDTH; no overflow flag.
  - SLT: signed compare; result is 1 or 0.
  - AND, OR: bitwise.
- Reserved codes: result_o = 0, zero_o = 1, valid_o = 1.
- MUL accept:
  - Load multiplicand = data1_i, multiplier = data2_i, acc = 0, cnt = 0.
  - State goes to MUL; valid_o = 0.
- Each MUL-state edge:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; cnt++.
- MUL completion, on the edge where cnt reaches WIDTH:
  - result_o = low WIDTH bits of the product (identical for signed and unsigned operands).
  - valid_o = 1; state returns to IDLE.
- valid_o is low on every edge that does not complete an operation; result_o/zero_o hold their last value.
- flush_i high at an edge:
  - State goes to IDLE and valid_o = 0.
  - Any MUL in flight is discarded.
  - An operation presented in the same cycle is not accepted.
  - result_o/zero_o are unchanged.

## Timing
- Reset values: result_o = 0, zero_o = 0, valid_o = 0, state IDLE, cnt = 0, acc = 0.
- ready_o is 0 while rst_i is high.
- Reset asserted mid-MUL aborts immediately; no valid_o is produced.
- Single-cycle latency: accepted at edge k, valid_o high in cycle k..k+1 (after edge k). Back-to-back accepts are allowed every cycle.
- MUL latency:
  - Accept at edge k; ready_o low after edge k.
  - valid_o is high and ready_o returns high after edge k+WIDTH.
  - The next operation can be accepted at edge k+WIDTH+1, giving a zero-bubble follow-on.
- No downstream backpressure: EX/MEM always captures a valid_o pulse.
- valid_i while ready_o = 0 is ignored. Upstream must hold the operation; the hazard unit stalls on !ready_o.

## Structure
- Package `alu_pkg`:
  - localparams for the six ctrl codes (CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_MUL).
  - State encoding (ST_IDLE, ST_MUL).
  - `ALU_Control` uses the same constants.
- Sub-module `mul_iter`:
  - Owns multiplicand, multiplier, acc and cnt.
  - Inputs: start, flush.
  - Outputs: done pulse and product.
- `alu_exec_unit` holds the FSM, the combinational single-cycle datapath, and the output registers.

## Test plan
- Reset: rst_i high mid-run → result_o = 0, zero_o = 0, valid_o = 0, ready_o = 0. After release, ready_o = 1.
- Back-to-back single-cycle ops, one per cycle, all with valid_o one cycle after accept:
  - ADD 7 + 5 → 12
  - SUB 5 − 7 → 0xFFFFFFFE
  - AND 0xF0F0 & 0x0FF0 → 0x00F0
  - OR → 0xFFF0
  - SLT (−1 vs 1) → 1
  - SUB 9 − 9 → 0 with zero_o = 1
- MUL timing:
  - MUL 123 × 456 → ready_o low for exactly 32 cycles; valid_o on edge k+32 with result 56088.
  - Op held on valid_i during MUL is accepted at edge k+33.
- MUL wrap: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; 0x80000000 × 2 → 0 with zero_o = 1.
- Flush:
  - flush_i at cycle 10 of a MUL → no valid_o; ready_o high next cycle; result_o keeps its previous value.
  - flush_i with valid_i ADD in the same cycle → not accepted.
- Reserved code 100 with operands 3, 4 → result_o = 0, zero_o = 1, valid_o = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU_Control operation codes and execute-unit state encoding.
// ALU_Control produces these same codes, so both sides stay in step.
package alu_pkg;

   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_OR  = 3'b001;
   localparam logic [2:0] CTRL_ADD = 3'b010;
   localparam logic [2:0] CTRL_SUB = 3'b110;
   localparam logic [2:0] CTRL_SLT = 3'b111;
   localparam logic [2:0] CTRL_MUL = 3'b011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
// done/product are combinational so the final partial sum is captured on the completing edge.
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt;
   logic             busy;

   assign acc_next = multiplier[0] ? acc + multiplicand : acc;
   assign done     = busy && !flush && (cnt == CW'(WIDTH - 1));
   assign product  = acc_next;

   // Bits shifted past WIDTH are dropped, giving the low half of the product.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         multiplicand <= '0;
         multiplier   <= '0;
         acc          <= '0;
         cnt          <= '0;
         busy         <= 1'b0;
      end else if (flush) begin
         busy <= 1'b0;
      end else if (start) begin
         multiplicand <= op_a;
         multiplier   <= op_b;
         acc          <= '0;
         cnt          <= '0;
         busy         <= 1'b1;
      end else if (busy) begin
         acc          <= acc_next;
         multiplicand <= multiplicand << 1;
         multiplier   <= multiplier >> 1;
         cnt          <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative MUL that
// drops ready_o so the hazard unit stalls the front of the pipeline.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             flush_i,
   input  logic [2:0]       ctrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] result_next;
   logic             load_result;

   assign ready_o   = (state == ST_IDLE) && !rst_i;
   assign accept    = valid_i && ready_o && !flush_i;
   assign mul_start = accept && (ctrl_i == CTRL_MUL);

   mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start  (mul_start),
      .flush  (flush_i),
      .op_a   (data1_i),
      .op_b   (data2_i),
      .done   (mul_done),
      .product(mul_product)
   );

   // Reserved codes fall through to zero so EX/MEM still sees a defined result.
   always_comb begin
      alu_result = '0;
      case (ctrl_i)
         CTRL_AND: alu_result = data1_i & data2_i;
         CTRL_OR:  alu_result = data1_i | data2_i;
         CTRL_ADD: alu_result = data1_i + data2_i;
         CTRL_SUB: alu_result = data1_i - data2_i;
         CTRL_SLT: alu_result = {{(WIDTH - 1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
         default:  alu_result = '0;
      endcase
   end

   always_comb begin
      state_next  = state;
      load_result = 1'b0;
      result_next = alu_result;
      if (flush_i) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (ctrl_i == CTRL_MUL) begin
                     state_next = ST_MUL;
                  end else begin
                     load_result = 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state_next  = ST_IDLE;
                  load_result = 1'b1;
                  result_next = mul_product;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_o <= '0;
         zero_o   <= 1'b0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= load_result;
         if (load_result) begin
            result_o <= result_next;
            zero_o   <= (result_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases with literal results, then random traffic
// compared every cycle against a countdown/arithmetic model of the unit.
module tb_alu_exec_unit;

   localparam int WIDTH = 32;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;
   localparam logic [2:0] OP_MUL = 3'b011;

   logic             clk_i   = 1'b0;
   logic             rst_i   = 1'b0;
   logic             valid_i = 1'b0;
   logic             flush_i = 1'b0;
   logic [2:0]       ctrl_i  = 3'b000;
   logic [WIDTH-1:0] data1_i = '0;
   logic [WIDTH-1:0] data2_i = '0;
   logic             ready_o;
   logic             valid_o;
   logic             zero_o;
   logic [WIDTH-1:0] result_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   alu_exec_unit #(
      .WIDTH(WIDTH)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .flush_i (flush_i),
      .ctrl_i  (ctrl_i),
      .data1_i (data1_i),
      .data2_i (data2_i),
      .valid_o (valid_o),
      .result_o(result_o),
      .zero_o  (zero_o)
   );

   task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] full;
      full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      case (c)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
         OP_MUL:  return full[WIDTH-1:0];
         default: return '0;
      endcase
   endfunction

   // Model: a MUL is just "busy for WIDTH more edges, then present a*b".
   logic             m_busy   = 1'b0;
   int               m_left   = 0;
   logic             m_valid  = 1'b0;
   logic [WIDTH-1:0] m_result = '0;
   logic [WIDTH-1:0] m_prod   = '0;
   logic             m_zero   = 1'b0;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_busy   = 1'b0;
         m_left   = 0;
         m_valid  = 1'b0;
         m_result = '0;
         m_zero   = 1'b0;
      end else if (flush_i) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
      end else if (m_busy) begin
         m_left--;
         m_valid = 1'b0;
         if (m_left == 0) begin
            m_busy   = 1'b0;
            m_valid  = 1'b1;
            m_result = m_prod;
            m_zero   = (m_prod == '0);
         end
      end else if (valid_i) begin
         if (ctrl_i == OP_MUL) begin
            m_busy  = 1'b1;
            m_left  = WIDTH;
            m_prod  = ref_op(ctrl_i, data1_i, data2_i);
            m_valid = 1'b0;
         end else begin
            m_valid  = 1'b1;
            m_result = ref_op(ctrl_i, data1_i, data2_i);
            m_zero   = (m_result == '0);
         end
      end else begin
         m_valid = 1'b0;
      end
   end

   always @(negedge clk_i) begin
      check_output("cmp_ready", WIDTH'(ready_o), WIDTH'(!m_busy && !rst_i));
      check_output("cmp_valid", WIDTH'(valid_o), WIDTH'(m_valid));
      check_output("cmp_result", result_o, m_result);
      check_output("cmp_zero", WIDTH'(zero_o), WIDTH'(m_zero));
   end

   task automatic apply_stimulus(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic f);
      @(posedge clk_i);
      #1;
      valid_i = v;
      ctrl_i  = c;
      data1_i = a;
      data2_i = b;
      flush_i = f;
   endtask

   // Called one step after the MUL accept edge; returns how many sampled cycles ready_o stayed low.
   task automatic wait_mul(output int low_cycles);
      low_cycles = 0;
      while (ready_o == 1'b0 && low_cycles < 100) begin
         low_cycles++;
         @(posedge clk_i);
         #1;
      end
   endtask

   function automatic logic [WIDTH-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(WIDTH - 1){1'b0}}};
         3:       return {1'b0, {(WIDTH - 1){1'b1}}};
         4:       return WIDTH'($urandom_range(0, 15));
         default: return WIDTH'($urandom);
      endcase
   endfunction

   typedef struct {
      logic [2:0]       c;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
      logic             z;
   } vec_t;

   vec_t vecs[6];
   int   low;
   logic saw_valid;

   initial begin
      vecs[0] = '{OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0};
      vecs[1] = '{OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0};
      vecs[2] = '{OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
      vecs[3] = '{OP_OR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0};
      vecs[4] = '{OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
      vecs[5] = '{OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1};

      #1 rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check_output("reset_ready", WIDTH'(ready_o), WIDTH'(0));
      check_output("reset_valid", WIDTH'(valid_o), WIDTH'(0));
      check_output("reset_result", result_o, '0);
      rst_i = 1'b0;
      #1;
      check_output("release_ready", WIDTH'(ready_o), WIDTH'(1));

      // Back-to-back single-cycle ops; each result is checked one edge after its accept.
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) apply_stimulus(1'b1, vecs[i].c, vecs[i].a, vecs[i].b, 1'b0);
         else       apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
         if (i > 0) begin
            check_output($sformatf("b2b_valid_%0d", i - 1), WIDTH'(valid_o), WIDTH'(1));
            check_output($sformatf("b2b_result_%0d", i - 1), result_o, vecs[i-1].r);
            check_output($sformatf("b2b_zero_%0d", i - 1), WIDTH'(zero_o), WIDTH'(vecs[i-1].z));
         end
      end

      // MUL with a follow-on ADD held on valid_i throughout the stall.
      apply_stimulus(1'b1, OP_MUL, 32'd123, 32'd456, 1'b0);
      apply_stimulus(1'b1, OP_ADD, 32'd100, 32'd23, 1'b0);
      wait_mul(low);
      check_output("mul_low_cycles", WIDTH'(low), WIDTH'(32));
      check_output("mul_valid", WIDTH'(valid_o), WIDTH'(1));
      check_output("mul_result", result_o, 32'd56088);
      @(posedge clk_i);
      #1;
      check_output("followon_valid", WIDTH'(valid_o), WIDTH'(1));
      check_output("followon_result", result_o, 32'd123);
      valid_i = 1'b0;

      apply_stimulus(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      wait_mul(low);
      check_output("wrap1_result", result_o, 32'd1);
      apply_stimulus(1'b1, OP_MUL, 32'h8000_0000, 32'd2, 1'b0);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      wait_mul(low);
      check_output("wrap2_result", result_o, 32'd0);
      check_output("wrap2_zero", WIDTH'(zero_o), WIDTH'(1));

      // Flush a MUL part-way through; the old result must survive.
      apply_stimulus(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
      apply_stimulus(1'b1, OP_MUL, 32'd5, 32'd6, 1'b0);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      repeat (9) @(posedge clk_i);
      #1 flush_i = 1'b1;
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      check_output("flush_valid", WIDTH'(valid_o), WIDTH'(0));
      check_output("flush_ready", WIDTH'(ready_o), WIDTH'(1));
      check_output("flush_result", result_o, 32'd3);
      saw_valid = 1'b0;
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (valid_o) saw_valid = 1'b1;
      end
      check_output("flush_no_late_valid", WIDTH'(saw_valid), WIDTH'(0));

      apply_stimulus(1'b1, OP_ADD, 32'd10, 32'd20, 1'b1);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      check_output("flush_add_valid", WIDTH'(valid_o), WIDTH'(0));
      check_output("flush_add_result", result_o, 32'd3);

      apply_stimulus(1'b1, 3'b100, 32'd3, 32'd4, 1'b0);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      check_output("rsvd_valid", WIDTH'(valid_o), WIDTH'(1));
      check_output("rsvd_result", result_o, 32'd0);
      check_output("rsvd_zero", WIDTH'(zero_o), WIDTH'(1));

      // Asynchronous reset in the middle of a MUL.
      apply_stimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
      apply_stimulus(1'b1, OP_MUL, 32'd7, 32'd8, 1'b0);
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      repeat (5) @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check_output("midrst_ready", WIDTH'(ready_o), WIDTH'(0));
      check_output("midrst_valid", WIDTH'(valid_o), WIDTH'(0));
      check_output("midrst_result", result_o, 32'd0);
      check_output("midrst_zero", WIDTH'(zero_o), WIDTH'(0));
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1;
      check_output("midrst_release_ready", WIDTH'(ready_o), WIDTH'(1));

      for (int n = 0; n < 600; n++) begin
         apply_stimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(),
                        pick_operand(), $urandom_range(0, 39) == 0);
      end
      apply_stimulus(1'b0, OP_AND, '0, '0, 1'b0);
      repeat (40) @(posedge clk_i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
